// File: rtl/key_debounce.sv
// Key debouncer: synchronizer, four-state debounce FSM, press/release strobes.
// Optional long-press strobe enabled by defining KEY_DEBOUNCE_LONGPRESS_EN.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_raw_key,
  output logic out_key_level,
  output logic out_press_pulse,
  output logic out_release_pulse,
  output logic out_long_press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic            PIN_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic [1:0]             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   level_reg, level_next;
  logic                   press_reg, press_next;
  logic                   release_reg, release_next;

  // Reset parks the chain at the released pin level so a held key must re-debounce.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      sync_reg <= {SYNC_STAGES{PIN_IDLE}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_raw_key};
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync_reg[SYNC_STAGES-1] : sync_reg[SYNC_STAGES-1];

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (s) begin
          state_next = ST_PRESS_CHK;
          cnt_next   = CNT_ONE;
        end
      end
      ST_PRESS_CHK: begin
        if (!s) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_PRESSED;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_next = ST_REL_CHK;
          cnt_next   = CNT_ONE;
        end
      end
      ST_REL_CHK: begin
        // A short return to pressed is a glitch: level and long-press count survive it.
        if (s) begin
          state_next = ST_PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = ST_IDLE;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign out_key_level     = level_reg;
  assign out_press_pulse   = press_reg;
  assign out_release_pulse = release_reg;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam int               LONG_W    = $clog2(LONG_CYCLES) + 1;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);

  logic [LONG_W-1:0] long_cnt_reg;
  logic              long_pulse_reg;
  logic              held;

  assign held = (state_reg == ST_PRESSED) || (state_reg == ST_REL_CHK);

  // Saturates at LONG_LAST, so the strobe fires at most once per accepted press.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      long_cnt_reg   <= '0;
      long_pulse_reg <= 1'b0;
    end else begin
      long_pulse_reg <= 1'b0;
      if (state_next == ST_IDLE) begin
        long_cnt_reg <= '0;
      end else if (held && (long_cnt_reg != LONG_LAST)) begin
        long_cnt_reg <= long_cnt_reg + LONG_W'(1);
        if (long_cnt_reg == LONG_PRE) begin
          long_pulse_reg <= 1'b1;
        end
      end
    end
  end

  assign out_long_press = long_pulse_reg;
`else
  // LONG_CYCLES is still referenced so the parameter stays part of the interface.
  assign out_long_press = 1'b0 & (LONG_CYCLES != 0);
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected events are queued with stimulus,
// observed strobes/level changes are queued by a monitor and compared per test.
module tb_key_debounce;
  localparam int DEB = 8, SYNC = 2, ACT = 1, LONG = 32;
  localparam int K_PRESS = 1, K_REL = 2, K_LONG = 3, K_LVL = 5;
  localparam int K_PNOLVL = 6, K_RNOLVL = 7, K_BOTH = 9;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  logic in_raw_key = 1'b1;
  logic out_key_level, out_press_pulse, out_release_pulse, out_long_press;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(ACT), .LONG_CYCLES(LONG)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_raw_key(in_raw_key),
    .out_key_level(out_key_level), .out_press_pulse(out_press_pulse),
    .out_release_pulse(out_release_pulse), .out_long_press(out_long_press)
  );

  always #5 in_clk = ~in_clk;

  int cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  bit mon_en = 1'b0;
  logic prev_level = 1'b0;
  int exp_cyc[$], exp_kind[$], obs_cyc[$], obs_kind[$];

  // Monitor: every strobe or level change becomes an observed event tagged with its edge.
  always @(negedge in_clk) begin
    if (mon_en) begin
      if (out_press_pulse === 1'b1 && out_release_pulse === 1'b1) begin
        obs_cyc.push_back(cyc); obs_kind.push_back(K_BOTH);
      end else if (out_press_pulse === 1'b1) begin
        obs_cyc.push_back(cyc);
        obs_kind.push_back((out_key_level === 1'b1 && prev_level === 1'b0) ? K_PRESS : K_PNOLVL);
      end else if (out_release_pulse === 1'b1) begin
        obs_cyc.push_back(cyc);
        obs_kind.push_back((out_key_level === 1'b0 && prev_level === 1'b1) ? K_REL : K_RNOLVL);
      end else if (out_key_level !== prev_level) begin
        obs_cyc.push_back(cyc); obs_kind.push_back(K_LVL);
      end
      if (out_long_press === 1'b1) begin
        obs_cyc.push_back(cyc); obs_kind.push_back(K_LONG);
      end
    end
    prev_level <= out_key_level;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic test_reset();
    tick(3);
    total++; if (out_key_level !== 1'b0) begin bad++; $display("FAIL reset_level: got %b want 0", out_key_level); end
    total++; if (out_press_pulse !== 1'b0) begin bad++; $display("FAIL reset_press: got %b want 0", out_press_pulse); end
    total++; if (out_release_pulse !== 1'b0) begin bad++; $display("FAIL reset_release: got %b want 0", out_release_pulse); end
    total++; if (out_long_press !== 1'b0) begin bad++; $display("FAIL reset_long: got %b want 0", out_long_press); end
    in_rst = 1'b0;
    mon_en = 1'b1;
    tick(15);
    total++;
    if (obs_kind.size() != 0) begin
      bad++;
      $display("FAIL reset_idle: %0d events, first kind=%0d at cycle %0d, want none", obs_kind.size(), obs_kind[0], obs_cyc[0]);
      obs_kind.delete(); obs_cyc.delete();
    end else $display("reset_idle: quiet after reset");
  endtask

  task automatic test_clean_press();
    int e;
    e = cyc;
    in_raw_key = 1'b0;
    exp_cyc.push_back(e + 10); exp_kind.push_back(K_PRESS);
    tick(14);
    while (exp_kind.size() > 0) begin
      int ec, ek, oc, ok;
      ec = exp_cyc.pop_front(); ek = exp_kind.pop_front(); oc = -1; ok = 0;
      if (obs_kind.size() > 0) begin oc = obs_cyc.pop_front(); ok = obs_kind.pop_front(); end
      total++;
      if (ok !== ek || oc !== ec) begin bad++; $display("FAIL clean_press: kind=%0d cycle=%0d want kind=%0d cycle=%0d", ok, oc, ek, ec); end
      else $display("clean_press: kind=%0d at cycle %0d", ok, oc);
    end
    total++;
    if (obs_kind.size() != 0) begin bad++; $display("FAIL clean_press_extra: kind=%0d cycle=%0d want none", obs_kind[0], obs_cyc[0]); obs_kind.delete(); obs_cyc.delete(); end
    total++; if (out_key_level !== 1'b1) begin bad++; $display("FAIL clean_press_level: got %b want 1", out_key_level); end
  endtask

  task automatic test_release();
    int e;
    e = cyc;
    in_raw_key = 1'b1;
    exp_cyc.push_back(e + 10); exp_kind.push_back(K_REL);
    tick(14);
    while (exp_kind.size() > 0) begin
      int ec, ek, oc, ok;
      ec = exp_cyc.pop_front(); ek = exp_kind.pop_front(); oc = -1; ok = 0;
      if (obs_kind.size() > 0) begin oc = obs_cyc.pop_front(); ok = obs_kind.pop_front(); end
      total++;
      if (ok !== ek || oc !== ec) begin bad++; $display("FAIL release: kind=%0d cycle=%0d want kind=%0d cycle=%0d", ok, oc, ek, ec); end
      else $display("release: kind=%0d at cycle %0d", ok, oc);
    end
    total++;
    if (obs_kind.size() != 0) begin bad++; $display("FAIL release_extra: kind=%0d cycle=%0d want none", obs_kind[0], obs_cyc[0]); obs_kind.delete(); obs_cyc.delete(); end
    total++; if (out_key_level !== 1'b0) begin bad++; $display("FAIL release_level: got %b want 0", out_key_level); end
  endtask

  task automatic test_bounce();
    int e;
    e = cyc;
    in_raw_key = 1'b0;
    tick(5);
    in_raw_key = 1'b1;
    tick(1);
    in_raw_key = 1'b0;
    exp_cyc.push_back(e + 16); exp_kind.push_back(K_PRESS);
    tick(13);
    in_raw_key = 1'b1;
    exp_cyc.push_back(e + 29); exp_kind.push_back(K_REL);
    tick(14);
    while (exp_kind.size() > 0) begin
      int ec, ek, oc, ok;
      ec = exp_cyc.pop_front(); ek = exp_kind.pop_front(); oc = -1; ok = 0;
      if (obs_kind.size() > 0) begin oc = obs_cyc.pop_front(); ok = obs_kind.pop_front(); end
      total++;
      if (ok !== ek || oc !== ec) begin bad++; $display("FAIL bounce: kind=%0d cycle=%0d want kind=%0d cycle=%0d", ok, oc, ek, ec); end
      else $display("bounce: kind=%0d at cycle %0d", ok, oc);
    end
    total++;
    if (obs_kind.size() != 0) begin bad++; $display("FAIL bounce_extra: kind=%0d cycle=%0d want none", obs_kind[0], obs_cyc[0]); obs_kind.delete(); obs_cyc.delete(); end
  endtask

  task automatic test_release_glitch();
    int e;
    e = cyc;
    in_raw_key = 1'b0;
    exp_cyc.push_back(e + 10); exp_kind.push_back(K_PRESS);
    tick(14);
    in_raw_key = 1'b1;
    tick(3);
    in_raw_key = 1'b0;
    tick(9);
    total++; if (out_key_level !== 1'b1) begin bad++; $display("FAIL glitch_level: got %b want 1", out_key_level); end
    in_raw_key = 1'b1;
    exp_cyc.push_back(e + 36); exp_kind.push_back(K_REL);
    tick(14);
    while (exp_kind.size() > 0) begin
      int ec, ek, oc, ok;
      ec = exp_cyc.pop_front(); ek = exp_kind.pop_front(); oc = -1; ok = 0;
      if (obs_kind.size() > 0) begin oc = obs_cyc.pop_front(); ok = obs_kind.pop_front(); end
      total++;
      if (ok !== ek || oc !== ec) begin bad++; $display("FAIL glitch: kind=%0d cycle=%0d want kind=%0d cycle=%0d", ok, oc, ek, ec); end
      else $display("glitch: kind=%0d at cycle %0d", ok, oc);
    end
    total++;
    if (obs_kind.size() != 0) begin bad++; $display("FAIL glitch_extra: kind=%0d cycle=%0d want none", obs_kind[0], obs_cyc[0]); obs_kind.delete(); obs_cyc.delete(); end
  endtask

  task automatic test_long_press();
    int e;
    e = cyc;
    in_raw_key = 1'b0;
    exp_cyc.push_back(e + 10); exp_kind.push_back(K_PRESS);
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    exp_cyc.push_back(e + 10 + LONG - 1); exp_kind.push_back(K_LONG);
`endif
    tick(70);
    in_raw_key = 1'b1;
    exp_cyc.push_back(e + 80); exp_kind.push_back(K_REL);
    tick(14);
    while (exp_kind.size() > 0) begin
      int ec, ek, oc, ok;
      ec = exp_cyc.pop_front(); ek = exp_kind.pop_front(); oc = -1; ok = 0;
      if (obs_kind.size() > 0) begin oc = obs_cyc.pop_front(); ok = obs_kind.pop_front(); end
      total++;
      if (ok !== ek || oc !== ec) begin bad++; $display("FAIL long_press: kind=%0d cycle=%0d want kind=%0d cycle=%0d", ok, oc, ek, ec); end
      else $display("long_press: kind=%0d at cycle %0d", ok, oc);
    end
    total++;
    if (obs_kind.size() != 0) begin bad++; $display("FAIL long_press_extra: kind=%0d cycle=%0d want none", obs_kind[0], obs_cyc[0]); obs_kind.delete(); obs_cyc.delete(); end
  endtask

  task automatic test_reset_mid_press();
    int e;
    e = cyc;
    in_raw_key = 1'b0;
    exp_cyc.push_back(e + 10); exp_kind.push_back(K_PRESS);
    tick(14);
    in_rst = 1'b1;
    // Level drops through reset with no release strobe.
    exp_cyc.push_back(e + 15); exp_kind.push_back(K_LVL);
    tick(1);
    total++; if (out_key_level !== 1'b0) begin bad++; $display("FAIL midrst_level: got %b want 0", out_key_level); end
    total++; if (out_press_pulse !== 1'b0) begin bad++; $display("FAIL midrst_press: got %b want 0", out_press_pulse); end
    total++; if (out_release_pulse !== 1'b0) begin bad++; $display("FAIL midrst_release: got %b want 0", out_release_pulse); end
    total++; if (out_long_press !== 1'b0) begin bad++; $display("FAIL midrst_long: got %b want 0", out_long_press); end
    in_rst = 1'b0;
    exp_cyc.push_back(e + 25); exp_kind.push_back(K_PRESS);
    tick(12);
    in_raw_key = 1'b1;
    exp_cyc.push_back(e + 37); exp_kind.push_back(K_REL);
    tick(12);
    while (exp_kind.size() > 0) begin
      int ec, ek, oc, ok;
      ec = exp_cyc.pop_front(); ek = exp_kind.pop_front(); oc = -1; ok = 0;
      if (obs_kind.size() > 0) begin oc = obs_cyc.pop_front(); ok = obs_kind.pop_front(); end
      total++;
      if (ok !== ek || oc !== ec) begin bad++; $display("FAIL midrst: kind=%0d cycle=%0d want kind=%0d cycle=%0d", ok, oc, ek, ec); end
      else $display("midrst: kind=%0d at cycle %0d", ok, oc);
    end
    total++;
    if (obs_kind.size() != 0) begin bad++; $display("FAIL midrst_extra: kind=%0d cycle=%0d want none", obs_kind[0], obs_cyc[0]); obs_kind.delete(); obs_cyc.delete(); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release_glitch();
    test_long_press();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable-sample count required to accept a level change (minimum 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth (minimum 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means a pressed key drives in_raw_key low.
REQ-004 SHALL have parameter LONG_CYCLES, default 50000000, pressed-hold count for a long press (minimum 2).
REQ-005 SHALL have port in_clk, input, 1, sole clock. All logic runs on its rising edge.
REQ-006 SHALL have port in_rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port in_raw_key, input, 1, asynchronous, bouncing physical key pin.
REQ-008 SHALL have port out_key_level, output, 1, debounced pressed level, active-high; feeds the key-press stage's in_phiz_key.
REQ-009 SHALL have port out_press_pulse, output, 1, one-cycle strobe on an accepted press.
REQ-010 SHALL have port out_release_pulse, output, 1, one-cycle strobe on an accepted release.
REQ-011 SHALL have port out_long_press, output, 1, one-cycle strobe on a long press (see Configuration).

Function
REQ-012 SHALL pass in_raw_key through a SYNC_STAGES-deep flop chain, then invert it when ACTIVE_LOW=1, producing the internal active-high sample "s".
REQ-013 SHALL use a four-state FSM:
- IDLE (released, stable)
- PRESS_CHK
- PRESSED (pressed, stable)
- REL_CHK
REQ-014 IDLE: s=1 -> PRESS_CHK, with the counter loaded to 1; s=0 -> stay in IDLE.
REQ-015 PRESS_CHK: s=0 -> IDLE, counter cleared, no pulse; s=1 with counter < DEBOUNCE_CYCLES-1 -> counter increments.
REQ-016 PRESS_CHK: s=1 with counter = DEBOUNCE_CYCLES-1 -> PRESSED; out_key_level rises and out_press_pulse is high for that single cycle.
REQ-017 PRESSED: s=0 -> REL_CHK, with the counter loaded to 1.
REQ-018 REL_CHK: s=1 -> PRESSED, counter cleared, no pulse. This is a glitch; out_key_level stays 1 and the long-press counter is not cleared.
REQ-019 REL_CHK: s=0 with counter = DEBOUNCE_CYCLES-1 -> IDLE; out_key_level falls and out_release_pulse is high for that single cycle.
REQ-020 Latency: a clean press held steady SHALL assert out_key_level exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after in_raw_key first changes to pressed. Release latency SHALL be identical.
REQ-021 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits. It SHALL never wrap.
REQ-022 out_press_pulse and out_release_pulse SHALL never be high in the same cycle. Each pulse SHALL last exactly one cycle.
REQ-023 out_key_level SHALL change only on the PRESS_CHK->PRESSED and REL_CHK->IDLE transitions.

Reset
REQ-024 in_rst=1 SHALL force the following on the next edge, regardless of current state:
- state = IDLE
- all counters = 0
- synchronizer flops = the inactive pin level (1 if ACTIVE_LOW=1, else 0)
- out_key_level = out_press_pulse = out_release_pulse = out_long_press = 0
REQ-025 Reset asserted mid-press SHALL NOT produce a release pulse. After reset deasserts with the key still held, a full press debounce SHALL be required before out_key_level rises.

Configuration
REQ-026 Macro KEY_DEBOUNCE_LONGPRESS_EN SHALL control long-press detection.
REQ-027 With the macro defined:
- a saturating counter of width $clog2(LONG_CYCLES)+1 increments every cycle the FSM is in PRESSED or REL_CHK;
- it is cleared on entry to IDLE;
- out_long_press pulses for one cycle when the count reaches LONG_CYCLES-1, i.e. LONG_CYCLES-1 cycles after the out_press_pulse cycle, at most once per accepted press.
REQ-028 Without the macro: out_long_press SHALL be tied to 0 and no long-press counter SHALL be synthesized.

Verification
Bench parameters: DEBOUNCE_CYCLES=8, SYNC_STAGES=2, ACTIVE_LOW=1, LONG_CYCLES=32.
REQ-029 Clean press: in_raw_key 1->0 at edge 0, held -> out_key_level=1 and out_press_pulse=1 at edge 10 only.
REQ-030 Bounce: in_raw_key low for 5 cycles, high for 1 cycle, then low steady -> no pulse during the bounce; out_press_pulse occurs 10 edges after the final falling transition.
REQ-031 Release glitch: key held pressed, then high for 3 cycles, then low again -> out_key_level stays 1; no out_release_pulse.
REQ-032 Long press (macro defined): key held for 60 cycles after out_press_pulse -> exactly one out_long_press, 31 cycles after out_press_pulse. With the macro undefined, out_long_press stays 0 throughout.
REQ-033 Reset mid-press: in_rst pulsed for 1 cycle while out_key_level=1 and key still held -> all outputs 0 the next cycle; no release pulse; out_press_pulse re-occurs 10 edges after in_rst deasserts.
REQ-034 Release: key released after a press -> out_key_level=0 and out_release_pulse=1 on the same single cycle, 10 edges after in_raw_key returns high.
